inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Writer side of the instruction memory. It receives a byte stream from the host link and assembles
//  INST_WIDTH-bit instruction words, little-endian. Each word is written sequentially into instruction
//  memory through inst_write_addr/inst_write_data/inst_write_enable. The controller is held in reset
//  (core_reset) until the whole program is stored, then released so it fetches from address 0.
// PARAMETERS
//  INST_WIDTH  32  instruction word width in bits; INST_BYTES = ceil(INST_WIDTH/8)
//  INST_DEPTH  8   instruction address width; memory holds 2**INST_DEPTH words
//  AUTO_START  1   1: enter HDR directly after reset release; 0: wait in IDLE for start
// PORTS
//  clk                clock
//  reset              input   1             asynchronous, active-low reset
//  start              input   1             pulse: arm a new load (honoured only in IDLE/DONE)
//  s_data             input   8             host stream byte
//  s_valid            input   1             s_data valid
//  s_ready            output  1             loader accepts byte this cycle
//  inst_write_addr    output  INST_DEPTH    instruction memory write address
//  inst_write_data    output  INST_WIDTH    instruction word to write
//  inst_write_enable  output  1             one-cycle write strobe
//  core_reset         output  1             active-high reset to controller; 0 = program running
//  busy               output  1             1 in HDR/LOAD/WRITE
//  done               output  1             1 in DONE
//  error              output  1             sticky: header count out of range
//  loaded_count       output  INST_DEPTH+1  words written in current/last load
// BEHAVIOUR
//  - Reset (reset=0): s_ready=0, inst_write_enable=0, inst_write_addr=0, inst_write_data=0,
//    core_reset=1, busy=0, done=0, error=0, loaded_count=0; state=IDLE. Leaving reset:
//    AUTO_START=1 -> HDR next cycle; else IDLE.
//  - Byte handshake: byte consumed iff s_valid & s_ready at posedge. s_ready=1 only in HDR and LOAD.
//  - IDLE: start=1 -> HDR; clear error, loaded_count, addr=0, core_reset=1.
//  - HDR: consume 2 bytes, count N = {byte1,byte0}, 16-bit.
//    N==0 -> DONE with no writes.
//    N > 2**INST_DEPTH -> error=1, DONE, no writes, core_reset stays 1.
//    Otherwise remaining=N -> LOAD.
//  - LOAD: byte k of word (k=0..INST_BYTES-1) goes to bits [8k+7:8k] of the assembly register.
//    Bits above INST_WIDTH in the last byte are discarded. After byte INST_BYTES-1 is consumed -> WRITE.
//  - WRITE (exactly 1 cycle, s_ready=0): inst_write_enable=1, inst_write_data=assembled word,
//    inst_write_addr=current addr; all three registered outputs.
//    Next cycle: addr+1, loaded_count+1, remaining-1. remaining==0 -> DONE; else LOAD.
//  - Latency: write strobe occurs the cycle after the last byte of the word is accepted.
//    Throughput: INST_BYTES+1 cycles per word with s_valid held high.
//  - Address wrap: N==2**INST_DEPTH writes addr 0..max. addr wraps to 0 after the last word but is
//    never written again.
//  - DONE: done=1. core_reset=0 iff error==0, so controller reset deasserts the cycle DONE is entered.
//    start=1 -> HDR with core_reset=1, addr=0, loaded_count=0, error=0.
//  - start in HDR/LOAD/WRITE is ignored. Bytes offered while s_ready=0 are not consumed.
//  - inst_write_enable is 0 in every state except WRITE.
//  - Asynchronous reset mid-load: all outputs take reset values immediately; memory contents already
//    written are left unchanged; no partial word is written. The next load restarts at addr 0.
// TESTING
//  1. INST_WIDTH=32, stream 02 00 11 22 33 44 AA BB CC DD -> writes [0]=0x44332211, [1]=0xDDCCBBAA,
//     done=1, core_reset=0, loaded_count=2.
//  2. Header 00 00 -> no inst_write_enable pulse, DONE the cycle after byte 2, core_reset=0.
//  3. INST_DEPTH=8, header 01 01 (N=257) -> error=1, done=1, core_reset stays 1, zero writes.
//  4. Case 1 with random s_valid gaps and 256-word load -> identical memory image; addrs 0..255 each
//     written exactly once.
//  5. reset=0 after 3rd byte of word 1, then restart with case 1 -> no write at addr 1 before reset;
//     final image equals case 1.
//  6. start pulsed during LOAD -> ignored; start in DONE -> core_reset=1, second program loads from addr 0.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction-memory loader: turns a host byte stream (2-byte count header, then little-endian
// words) into sequential memory writes and holds the controller in reset until the program is stored.
module inst_loader #(
  parameter int INST_WIDTH = 32,
  parameter int INST_DEPTH = 8,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [INST_DEPTH-1:0] inst_write_addr,
  output logic [INST_WIDTH-1:0] inst_write_data,
  output logic                  inst_write_enable,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [INST_DEPTH:0]   loaded_count
);

  localparam int INST_BYTES = (INST_WIDTH + 7) / 8;
  localparam int ASM_WIDTH  = INST_BYTES * 8;
  localparam int BIDX_WIDTH = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam logic [BIDX_WIDTH-1:0] LAST_BYTE = BIDX_WIDTH'(INST_BYTES - 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** INST_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            state_next_s;
  logic                  error_next_s;
  logic                  clear_s;
  logic                  accept_s;
  logic [15:0]           hdr_count_s;
  logic                  hdr_phase_r;
  logic [7:0]            hdr_lo_r;
  logic [16:0]           remaining_r;
  logic [BIDX_WIDTH-1:0] byte_idx_r;
  logic [ASM_WIDTH-1:0]  asm_r;
  logic [INST_DEPTH-1:0] addr_r;
  logic [INST_DEPTH:0]   loaded_count_r;
  logic                  s_ready_r;
  logic                  write_enable_r;
  logic                  core_reset_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;

  assign accept_s    = s_valid & s_ready_r;
  assign hdr_count_s = {s_data, hdr_lo_r};

  assign s_ready           = s_ready_r;
  assign inst_write_addr   = addr_r;
  assign inst_write_data   = asm_r[INST_WIDTH-1:0];
  assign inst_write_enable = write_enable_r;
  assign core_reset        = core_reset_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign error             = error_r;
  assign loaded_count      = loaded_count_r;

  // Next-state and sticky-error decision for the load sequence.
  always_comb begin
    state_next_s = state_r;
    error_next_s = error_r;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || AUTO_START) begin
          state_next_s = ST_HDR;
          error_next_s = 1'b0;
          clear_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (accept_s && hdr_phase_r) begin
          if (hdr_count_s == 16'd0) begin
            state_next_s = ST_DONE;
          end else if ({1'b0, hdr_count_s} > MAX_WORDS) begin
            state_next_s = ST_DONE;
            error_next_s = 1'b1;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (accept_s && (byte_idx_r == LAST_BYTE)) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (remaining_r == 17'd1) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s = ST_HDR;
          error_next_s = 1'b0;
          clear_s      = 1'b1;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and status outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      error_r        <= 1'b0;
      s_ready_r      <= 1'b0;
      write_enable_r <= 1'b0;
      core_reset_r   <= 1'b1;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      error_r        <= error_next_s;
      s_ready_r      <= (state_next_s == ST_HDR) || (state_next_s == ST_LOAD);
      write_enable_r <= (state_next_s == ST_WRITE);
      busy_r         <= (state_next_s == ST_HDR) || (state_next_s == ST_LOAD) ||
                        (state_next_s == ST_WRITE);
      done_r         <= (state_next_s == ST_DONE);
      // Controller runs only once a load has finished cleanly.
      core_reset_r   <= !((state_next_s == ST_DONE) && !error_next_s);
    end
  end

  // Header capture, word assembly and address/count bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_phase_r    <= 1'b0;
      hdr_lo_r       <= 8'd0;
      remaining_r    <= 17'd0;
      byte_idx_r     <= '0;
      asm_r          <= '0;
      addr_r         <= '0;
      loaded_count_r <= '0;
    end else if (clear_s) begin
      hdr_phase_r    <= 1'b0;
      byte_idx_r     <= '0;
      addr_r         <= '0;
      loaded_count_r <= '0;
    end else begin
      case (state_r)
        ST_HDR: begin
          if (accept_s) begin
            if (!hdr_phase_r) begin
              hdr_lo_r    <= s_data;
              hdr_phase_r <= 1'b1;
            end else begin
              remaining_r <= {1'b0, hdr_count_s};
              hdr_phase_r <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            asm_r[{byte_idx_r, 3'b000} +: 8] <= s_data;
            if (byte_idx_r == LAST_BYTE) begin
              byte_idx_r <= '0;
            end else begin
              byte_idx_r <= byte_idx_r + BIDX_WIDTH'(1);
            end
          end
        end
        ST_WRITE: begin
          // Address wraps naturally after a full-depth load; it is never written again.
          addr_r         <= addr_r + INST_DEPTH'(1);
          loaded_count_r <= loaded_count_r + (INST_DEPTH + 1)'(1);
          remaining_r    <= remaining_r - 17'd1;
        end
        default: begin
          hdr_phase_r <= hdr_phase_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a byte-count model predicts every output each cycle,
// plus literal checks for the documented example loads.
module tb_inst_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  inst_write_addr;
  logic [31:0] inst_write_data;
  logic        inst_write_enable;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  loaded_count;

  inst_loader #(.INST_WIDTH(32), .INST_DEPTH(8), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .inst_write_addr(inst_write_addr), .inst_write_data(inst_write_data),
    .inst_write_enable(inst_write_enable), .core_reset(core_reset), .busy(busy),
    .done(done), .error(error), .loaded_count(loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a load is a count of consumed bytes; everything follows from that count.
  bit          m_idle, m_active, m_done, m_err, m_wr, m_acc;
  int          m_bytes, m_n, m_written;
  logic [7:0]  m_hdr_lo;
  logic [31:0] m_word;
  logic [31:0] mem_exp [256];
  logic [31:0] mem_dut [256];
  int          wr_cnt  [256];
  int          wr_total = 0;
  logic [7:0]  stream [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wr = 1'b0; m_acc = 1'b0;
    m_bytes = 0; m_n = 0; m_written = 0;
  endtask

  task automatic model_update();
    int k;
    m_acc = 1'b0;
    if (m_wr) begin
      mem_exp[m_written % 256] = m_word;
      m_written++;
      m_wr = 1'b0;
      if (m_written == m_n) begin m_active = 1'b0; m_done = 1'b1; end
    end else if (m_active) begin
      if (s_valid) begin
        m_acc = 1'b1;
        m_bytes++;
        if (m_bytes == 1) begin
          m_hdr_lo = s_data;
        end else if (m_bytes == 2) begin
          m_n = int'({s_data, m_hdr_lo});
          if (m_n == 0) begin m_active = 1'b0; m_done = 1'b1; end
          else if (m_n > 256) begin m_active = 1'b0; m_done = 1'b1; m_err = 1'b1; end
        end else begin
          k = (m_bytes - 3) % 4;
          if (k == 0) m_word = 32'd0;
          m_word = m_word | (32'(s_data) << (8 * k));
          if (k == 3) m_wr = 1'b1;
        end
      end
    end else if (m_idle || (m_done && start)) begin
      m_idle = 1'b0; m_done = 1'b0; m_err = 1'b0; m_active = 1'b1;
      m_bytes = 0; m_n = 0; m_written = 0;
    end
  endtask

  task automatic compare();
    if (inst_write_enable === 1'b1) begin
      mem_dut[inst_write_addr] = inst_write_data;
      wr_cnt[inst_write_addr]++;
      wr_total++;
    end
    chk("s_ready", s_ready, m_active && !m_wr);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("core_reset", core_reset, !(m_done && !m_err));
    chk("write_enable", inst_write_enable, m_wr);
    chk("write_addr", inst_write_addr, m_written % 256);
    chk("loaded_count", loaded_count, m_written);
    if (m_wr) chk("write_data", inst_write_data, m_word);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_update();
    #1;
    compare();
  endtask

  task automatic send(input int gap_pct, input int start_pct);
    int idx = 0;
    int budget = stream.size() * 12 + 50;
    while (idx < stream.size() && budget > 0) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? stream[idx] : 8'($urandom);
      start   = ($urandom_range(99) < start_pct);
      step();
      if (m_acc) idx++;
      budget--;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    checks++;
    if (idx < stream.size()) begin
      errors++;
      $display("FAIL stream_timeout: got %0d bytes accepted expected %0d", idx, stream.size());
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      start   = 1'b0;
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; s_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic clear_image();
    for (int a = 0; a < 256; a++) begin
      mem_dut[a] = 32'd0; mem_exp[a] = 32'd0; wr_cnt[a] = 0;
    end
  endtask

  task automatic build_case1();
    stream = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  endtask

  task automatic build_random(input int n);
    stream = {};
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic check_image(input int n);
    for (int a = 0; a < n; a++) begin
      chk("image_count", wr_cnt[a], 1);
      chk("image_data", mem_dut[a], mem_exp[a]);
    end
  endtask

  initial begin
    int wr_before;
    reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    model_reset();
    clear_image();
    repeat (3) step();
    chk("reset_data", inst_write_data, 32'd0);
    reset = 1'b1;

    // Two-word example, start pulses during the load must be ignored.
    build_case1();
    send(0, 30);
    drain(3);
    chk("c1_word0", mem_dut[0], 32'h44332211);
    chk("c1_word1", mem_dut[1], 32'hDDCCBBAA);
    chk("c1_model0", mem_exp[0], 32'h44332211);
    chk("c1_done", done, 1'b1);
    chk("c1_core_reset", core_reset, 1'b0);
    chk("c1_loaded", loaded_count, 9'd2);

    // Empty program.
    wr_before = wr_total;
    pulse_start();
    stream = {8'h00, 8'h00};
    send(0, 0);
    chk("empty_done", done, 1'b1);
    chk("empty_core_reset", core_reset, 1'b0);
    drain(2);
    chk("empty_writes", wr_total, wr_before);
    chk("empty_loaded", loaded_count, 9'd0);

    // Count out of range.
    pulse_start();
    stream = {8'h01, 8'h01};
    send(0, 0);
    drain(3);
    chk("range_error", error, 1'b1);
    chk("range_done", done, 1'b1);
    chk("range_core_reset", core_reset, 1'b1);
    chk("range_writes", wr_total, wr_before);

    // Gapped two-word load, then a full-depth load.
    pulse_start();
    chk("restart_error_clear", error, 1'b0);
    clear_image();
    build_case1();
    send(40, 10);
    drain(3);
    chk("gap_word0", mem_dut[0], 32'h44332211);
    chk("gap_word1", mem_dut[1], 32'hDDCCBBAA);
    pulse_start();
    clear_image();
    build_random(256);
    send(30, 5);
    drain(3);
    check_image(256);
    chk("full_loaded", loaded_count, 9'd256);
    chk("full_addr_wrap", inst_write_addr, 8'd0);

    // Reset in the middle of word 1, then reload.
    pulse_start();
    clear_image();
    build_case1();
    stream = stream[0:8];
    send(20, 0);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    compare();
    chk("midreset_data", inst_write_data, 32'd0);
    chk("midreset_no_addr1", wr_cnt[1], 0);
    chk("midreset_addr0", wr_cnt[0], 1);
    reset = 1'b1;
    build_case1();
    send(25, 10);
    drain(3);
    chk("reload_word0", mem_dut[0], 32'h44332211);
    chk("reload_word1", mem_dut[1], 32'hDDCCBBAA);
    chk("reload_addr1_once", wr_cnt[1], 1);

    // Further programs started from DONE.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(12, 1);
      pulse_start();
      chk("restart_core_reset", core_reset, 1'b1);
      clear_image();
      build_random(n);
      send(35, 20);
      drain(3);
      check_image(n);
      chk("prog_loaded", loaded_count, 9'(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
